// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline-control constants and types, also used by the PC mux and the
// decoder's Tuse/Tnew table.
package pipe_hazard_ctrl_pkg;

  localparam logic [1:0] PCSEL_SEQ = 2'd0;
  localparam logic [1:0] PCSEL_EXC = 2'd1;
  localparam logic [1:0] PCSEL_EPC = 2'd2;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int MD_CNT_W        = 4;

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

  typedef struct packed {
    logic       pc_en;
    logic       fd_en;
    logic       fd_clr;
    logic       de_clr;
    logic       em_clr;
    logic [1:0] pc_sel;
  } hz_ctrl_t;

  // One producer/consumer pair: stall while the producer's result is not
  // forwardable before the consumer needs it. $0 is never a real dependency.
  function automatic logic src_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                      input logic [4:0] dst, input logic [1:0] tnew);
    return (tuse != TUSE_NONE) && (src != 5'd0) && (src == dst) && (tuse < tnew);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-information inputs and pipeline-advance controls of the hazard unit.
interface pipe_hazard_ctrl_if;
  logic [4:0] rs_d, rt_d;
  logic [1:0] tuse_rs_d, tuse_rt_d;
  logic [4:0] rd_e, rd_m;
  logic [1:0] tnew_e, tnew_m;
  logic       md_start_e, md_div_e, md_use_d;
  logic       exc_req_m, eret_m;
  logic       pc_en, fd_en;
  logic       fd_clr, de_clr, em_clr;
  logic [1:0] pc_sel;
  logic       md_busy;

  // Pipeline side: reports stage contents, consumes the controls.
  modport master (
    output rs_d, rt_d, tuse_rs_d, tuse_rt_d, rd_e, rd_m, tnew_e, tnew_m,
           md_start_e, md_div_e, md_use_d, exc_req_m, eret_m,
    input  pc_en, fd_en, fd_clr, de_clr, em_clr, pc_sel, md_busy
  );

  // Controller side.
  modport slave (
    input  rs_d, rt_d, tuse_rs_d, tuse_rt_d, rd_e, rd_m, tnew_e, tnew_m,
           md_start_e, md_div_e, md_use_d, exc_req_m, eret_m,
    output pc_en, fd_en, fd_clr, de_clr, em_clr, pc_sel, md_busy
  );
endinterface

// File: rtl/pipe_hazard_ctrl_md_busy_cnt.sv
// Mult/div occupancy counter: loads the op latency on a start, counts down to idle.
module md_busy_cnt
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start_e,
  input  logic md_div_e,
  output logic md_busy
);

  localparam logic [MD_CNT_W-1:0] MULT_LD = MD_CNT_W'(MULT_CYCLES);
  localparam logic [MD_CNT_W-1:0] DIV_LD  = MD_CNT_W'(DIV_CYCLES);

  logic [MD_CNT_W-1:0] cnt, cnt_nxt;
  md_state_t           state;

  assign state = (cnt == '0) ? MD_IDLE : MD_BUSY;

  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt_nxt;
  end

  // A start seen while busy is ignored; the window always runs to completion.
  always_comb begin
    cnt_nxt = cnt;
    case (state)
      MD_IDLE: if (md_start_e) cnt_nxt = md_div_e ? DIV_LD : MULT_LD;
      MD_BUSY: cnt_nxt = cnt - MD_CNT_W'(1);
      default: cnt_nxt = '0;
    endcase
  end

  always_comb begin
    md_busy = (state == MD_BUSY);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: data hazards, mult/div occupancy and M-stage
// exception/ERET redirection, with priority redirect > stall > run.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  pipe_hazard_ctrl_if.slave    hif
);

  logic     stall_data, stall_md, stall, redirect;
  logic     md_busy;
  hz_ctrl_t ctrl;

  md_busy_cnt #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_cnt (
    .clk        (clk),
    .reset      (reset),
    .md_start_e (hif.md_start_e),
    .md_div_e   (hif.md_div_e),
    .md_busy    (md_busy)
  );

  always_comb begin
    stall_data = src_hazard(hif.rs_d, hif.tuse_rs_d, hif.rd_e, hif.tnew_e)
               | src_hazard(hif.rs_d, hif.tuse_rs_d, hif.rd_m, hif.tnew_m)
               | src_hazard(hif.rt_d, hif.tuse_rt_d, hif.rd_e, hif.tnew_e)
               | src_hazard(hif.rt_d, hif.tuse_rt_d, hif.rd_m, hif.tnew_m);
    stall_md   = hif.md_use_d & (hif.md_start_e | md_busy);
    stall      = stall_data | stall_md;
    redirect   = hif.exc_req_m | hif.eret_m;
  end

  // Redirect flushes F/D, D/E and E/M but leaves an in-flight mult/div running.
  always_comb begin
    ctrl = '{pc_en: 1'b1, fd_en: 1'b1, fd_clr: 1'b0, de_clr: 1'b0,
             em_clr: 1'b0, pc_sel: PCSEL_SEQ};
    if (redirect) begin
      ctrl.fd_clr = 1'b1;
      ctrl.de_clr = 1'b1;
      ctrl.em_clr = 1'b1;
      ctrl.pc_sel = hif.exc_req_m ? PCSEL_EXC : PCSEL_EPC;
    end else if (stall) begin
      ctrl.pc_en  = 1'b0;
      ctrl.fd_en  = 1'b0;
      ctrl.de_clr = 1'b1;
    end
  end

  assign hif.pc_en   = ctrl.pc_en;
  assign hif.fd_en   = ctrl.fd_en;
  assign hif.fd_clr  = ctrl.fd_clr;
  assign hif.de_clr  = ctrl.de_clr;
  assign hif.em_clr  = ctrl.em_clr;
  assign hif.pc_sel  = ctrl.pc_sel;
  assign hif.md_busy = md_busy;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the five-stage pipeline. It produces the PC and F/D enables and the per-stage clears every cycle. It covers three cases: Tuse/Tnew data hazards, multi-cycle mult/div occupancy, and exception/ERET redirection from the M stage. It sits beside the PC, F/D, D/E, E/M and M/W registers and owns the only sequential state governing their advance: the mult/div busy counter.

## Interface
- `MULT_CYCLES`, 5: busy cycles after a mult/multu start.
- `DIV_CYCLES`, 10: busy cycles after a div/divu start.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `rs_d`, `rt_d` in 5 each: D-stage source register numbers.
- `tuse_rs_d`, `tuse_rt_d` in 2 each: cycles until the operand is needed. 3 means the operand is unused.
- `rd_e`, `rd_m` in 5 each: destination register in E and M.
- `tnew_e`, `tnew_m` in 2 each: cycles until that result is forwardable, counted from that stage.
- `md_start_e` in 1: a mult/div is issuing in E this cycle.
- `md_div_e` in 1: the issuing op is a divide.
- `md_use_d` in 1: the D instruction is mult/div, mfhi/mflo or mthi/mtlo.
- `exc_req_m` in 1: CP0 accepts an exception or interrupt for the M instruction.
- `eret_m` in 1: eret in M.
- `pc_en` out 1: PC register write enable.
- `fd_en` out 1: F/D register write enable.
- `fd_clr`, `de_clr`, `em_clr` out 1 each: synchronous clears, inserting a bubble.
- `pc_sel` out 2: 0 is sequential/branch, 1 is the exception vector, 2 is EPC.
- `md_busy` out 1: the mult/div unit is occupied.

## Operation
- Data stall:
  - `stall_data` = (rs_d≠0 & rs_d==rd_e & tuse_rs_d<tnew_e) | (rs_d≠0 & rs_d==rd_m & tuse_rs_d<tnew_m).
  - The same two terms apply for rt_d.
  - A tuse of 3 never stalls.
- Mult/div stall: `stall_md` = md_use_d & (md_start_e | md_busy).
- stall = stall_data | stall_md.
- Busy counter `cnt`, 4 bits, with states IDLE (cnt==0) and BUSY (cnt≠0):
  - IDLE with md_start_e: cnt ← md_div_e ? DIV_CYCLES : MULT_CYCLES.
  - BUSY: cnt ← cnt−1.
  - md_start_e while BUSY cannot occur, because the instruction is held by stall_md. If it does occur anyway, ignore it and keep counting.
  - md_busy = (cnt≠0).
- Output priority is redirect > stall > run.
  - Redirect (exc_req_m | eret_m): pc_en=1, fd_en=1, fd_clr=de_clr=em_clr=1. pc_sel=1 on exc_req_m, otherwise 2. exc_req_m wins if both are asserted. Stall is ignored.
  - Stall: pc_en=0, fd_en=0, de_clr=1, fd_clr=em_clr=0, pc_sel=0.
  - Run: pc_en=fd_en=1, all clears 0, pc_sel=0.
- A redirect does not cancel an in-flight mult/div. The counter keeps running and HI/LO complete normally.
- All outputs except md_busy are combinational from the inputs and cnt. md_busy is registered state.

## Timing
- Reset: cnt←0, so md_busy=0 on the cycle after the reset edge. While reset is high, the outputs still follow the combinational rules. The pipeline registers reset themselves.
- A start at edge k (md_start_e high in cycle k) gives md_busy high for cycles k+1 … k+N, where N = MULT_CYCLES or DIV_CYCLES. It is low in cycle k+N+1.
- A D-stage mflo that arrives during a busy window stalls through cycle k+N and advances at the edge ending k+N.
- Back-to-back starts: the second start is observed in E only after the window ends.
- Reset mid-count: cnt clears on that edge. There is no residual stall.

## Structure
- Shared package holds:
  - `PCSEL_SEQ`=0, `PCSEL_EXC`=1, `PCSEL_EPC`=2.
  - `TUSE_NONE`=3.
  - Default cycle counts.
- These constants are shared with the PC mux and the decoder's Tuse/Tnew table.
- One natural sub-module is `md_busy_cnt`, holding the counter and md_busy. Hazard comparison stays in the top level.

## Test plan
- rs_d=5, tuse_rs_d=0, rd_e=5, tnew_e=2 (lw in E): stall, meaning pc_en=0, fd_en=0, de_clr=1. Repeating with rs_d=0 gives no stall.
- rt_d=7, tuse_rt_d=1, rd_m=7, tnew_m=1: no stall. Changing tnew_m to 2 gives a stall.
- div start at cycle 10 with md_div_e=1 and DIV_CYCLES=10: md_busy high for cycles 11–20. An mflo held in D keeps pc_en=0 through cycle 20, and pc_en=1 in cycle 21.
- exc_req_m=1 together with a data stall: pc_en=1, pc_sel=1, fd_clr=de_clr=em_clr=1.
- eret_m=1 alone gives pc_sel=2. exc_req_m and eret_m together give pc_sel=1.
- reset at cycle 3 of a mult window: md_busy=0 on the next cycle, and an mfhi in D proceeds with no stall.
